fixp_acc_sum: RTL and testbench

Signed fixed-point accumulator that directly consumes the aligned words produced by the pipelined left shifter in the `fixp_acc` path. It sums a run-time-programmable number of shifted terms into a widened register and emits one sum per group on a stream master. Overflow is flagged per group, with optional saturation.

---
 rtl/fixp_acc_sum.sv | 107 ++++++++++
 tb/tb_fixp_acc_sum.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fixp_acc_sum.sv
// Signed fixed-point group accumulator: sums group_len aligned terms into a guard-widened register.
// Optional saturation on overflow is enabled by defining FIXP_ACC_SUM_SAT_EN.
module fixp_acc_sum #(
  parameter int DATA_WIDTH = 128,
  parameter int GUARD_BITS = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [LEN_WIDTH-1:0]             group_len,
  input  logic [DATA_WIDTH-1:0]            data_in_tdata,
  input  logic                             data_in_tvalid,
  output logic                             data_in_tready,
  output logic [DATA_WIDTH+GUARD_BITS-1:0] sum_out_tdata,
  output logic                             sum_out_tvalid,
  input  logic                             sum_out_tready,
  output logic                             sum_ovf,
  output logic                             busy
);

  localparam int ACC_WIDTH = DATA_WIDTH + GUARD_BITS;

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t                 state_reg, state_next;
  logic [ACC_WIDTH-1:0]   acc_reg, acc_next;
  logic [LEN_WIDTH-1:0]   remaining_reg, remaining_next;
  logic                   ovf_reg, ovf_next;
  logic                   tvalid_reg, busy_reg;

  logic [ACC_WIDTH-1:0]   ext_term;
  logic [ACC_WIDTH:0]     sum_wide;
  logic                   add_ovf;

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    remaining_next = remaining_reg;
    ovf_next       = ovf_reg;
    data_in_tready = (state_reg != EMIT);

    ext_term = {{GUARD_BITS{data_in_tdata[DATA_WIDTH-1]}}, data_in_tdata};
    // One extra bit so a disagreement between the top two bits exposes signed overflow.
    sum_wide = {acc_reg[ACC_WIDTH-1], acc_reg} + {ext_term[ACC_WIDTH-1], ext_term};
    add_ovf  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];

    case (state_reg)
      IDLE: begin
        if (data_in_tvalid) begin
          acc_next       = ext_term;
          ovf_next       = 1'b0;
          remaining_next = (group_len == '0) ? '0 : group_len - LEN_WIDTH'(1);
          state_next     = (remaining_next == '0) ? EMIT : ACCUM;
        end
      end
      ACCUM: begin
        if (data_in_tvalid) begin
          acc_next       = sum_wide[ACC_WIDTH-1:0];
          ovf_next       = ovf_reg | add_ovf;
`ifdef FIXP_ACC_SUM_SAT_EN
          // Clamp toward the sign of the addend that pushed the sum out of range.
          if (add_ovf) begin
            acc_next = data_in_tdata[DATA_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
          end
`endif
          remaining_next = remaining_reg - LEN_WIDTH'(1);
          if (remaining_reg == LEN_WIDTH'(1)) begin
            state_next = EMIT;
          end
        end
      end
      EMIT: begin
        if (sum_out_tready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      remaining_reg <= '0;
      ovf_reg       <= 1'b0;
      tvalid_reg    <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      remaining_reg <= remaining_next;
      ovf_reg       <= ovf_next;
      tvalid_reg    <= (state_next == EMIT);
      busy_reg      <= (state_next != IDLE);
    end
  end

  assign sum_out_tdata  = acc_reg;
  assign sum_out_tvalid = tvalid_reg;
  assign sum_ovf        = ovf_reg;
  assign busy           = busy_reg;

endmodule

// File: tb/tb_fixp_acc_sum.sv
// Directed self-checking bench for fixp_acc_sum, built narrow (8-bit terms, 1 guard bit) so sums are hand-checkable.
module tb_fixp_acc_sum;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] group_len;
  logic [7:0] data_in_tdata;
  logic       data_in_tvalid;
  logic       data_in_tready;
  logic [8:0] sum_out_tdata;
  logic       sum_out_tvalid;
  logic       sum_out_tready;
  logic       sum_ovf;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fixp_acc_sum #(.DATA_WIDTH(8), .GUARD_BITS(1), .LEN_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .group_len(group_len),
    .data_in_tdata(data_in_tdata), .data_in_tvalid(data_in_tvalid), .data_in_tready(data_in_tready),
    .sum_out_tdata(sum_out_tdata), .sum_out_tvalid(sum_out_tvalid), .sum_out_tready(sum_out_tready),
    .sum_ovf(sum_ovf), .busy(busy)
  );

  // Present one term and return at the falling edge after it was accepted.
  task automatic send(input logic [7:0] d, output bit ok);
    data_in_tvalid = 1'b1;
    data_in_tdata  = d;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (data_in_tready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_sum(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (sum_out_tvalid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic accept_sum();
    sum_out_tready = 1'b1;
    @(negedge clk);
    sum_out_tready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (sum_out_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", sum_out_tvalid); end
    total++; if (sum_out_tdata !== 9'h000) begin bad++; $display("FAIL reset_tdata got=%h want=000", sum_out_tdata); end
    total++; if (sum_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", sum_ovf); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (data_in_tready !== 1'b1) begin bad++; $display("FAIL reset_tready got=%b want=1", data_in_tready); end
    $display("reset: tvalid=%b tdata=%h ovf=%b busy=%b tready=%b", sum_out_tvalid, sum_out_tdata, sum_ovf, busy, data_in_tready);
  endtask

  task automatic test_basic();
    bit ok;
    bit all_ok = 1'b1;
    group_len = 4'd4;
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), ok);
      all_ok &= ok;
      if (i == 2) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
      end
    end
    data_in_tvalid = 1'b0;
    total++; if (!all_ok) begin bad++; $display("FAIL basic_send got=timeout want=accepted"); end
    total++; if (sum_out_tvalid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b want=1", sum_out_tvalid); end
    total++; if (sum_out_tdata !== 9'd10) begin bad++; $display("FAIL basic_sum got=%h want=00a", sum_out_tdata); end
    total++; if (sum_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", sum_ovf); end
    $display("basic: sum=%h ovf=%b", sum_out_tdata, sum_ovf);
    accept_sum();
    total++; if (sum_out_tvalid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_release got=%b%b want=00", sum_out_tvalid, busy); end
  endtask

  task automatic test_len_zero_one();
    bit ok;
    group_len = 4'd0;
    send(8'hFB, ok);
    data_in_tvalid = 1'b0;
    wait_sum(ok);
    total++; if (!ok) begin bad++; $display("FAIL len0_timeout got=none want=sum"); end
    total++; if (sum_out_tdata !== 9'h1FB) begin bad++; $display("FAIL len0_sum got=%h want=1fb", sum_out_tdata); end
    $display("len0: sum=%h", sum_out_tdata);
    accept_sum();
    group_len = 4'd1;
    send(8'd7, ok);
    data_in_tvalid = 1'b0;
    wait_sum(ok);
    total++; if (!ok) begin bad++; $display("FAIL len1_timeout got=none want=sum"); end
    total++; if (sum_out_tdata !== 9'd7) begin bad++; $display("FAIL len1_sum got=%h want=007", sum_out_tdata); end
    $display("len1: sum=%h", sum_out_tdata);
    accept_sum();
  endtask

  task automatic test_backpressure();
    bit ok;
    group_len = 4'd2;
    send(8'd5, ok);
    send(8'd6, ok);
    // Keep offering the next group's first term; it must not be taken during EMIT.
    data_in_tdata = 8'd3;
    for (int i = 0; i < 10; i++) begin
      total++; if (sum_out_tvalid !== 1'b1 || sum_out_tdata !== 9'd11) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h want=1/00b", i, sum_out_tvalid, sum_out_tdata); end
      total++; if (data_in_tready !== 1'b0) begin bad++; $display("FAIL bp_stall cyc=%0d got=%b want=0", i, data_in_tready); end
      @(negedge clk);
    end
    $display("backpressure: held sum=%h for 10 cycles", sum_out_tdata);
    sum_out_tready = 1'b1;
    total++; if (data_in_tready !== 1'b0) begin bad++; $display("FAIL bp_release_tready got=%b want=0", data_in_tready); end
    @(negedge clk);
    sum_out_tready = 1'b0;
    send(8'd3, ok);
    send(8'd4, ok);
    data_in_tvalid = 1'b0;
    wait_sum(ok);
    total++; if (!ok || sum_out_tdata !== 9'd7) begin bad++; $display("FAIL bp_next_sum got=%h want=007", sum_out_tdata); end
    $display("backpressure: next sum=%h", sum_out_tdata);
    accept_sum();
  endtask

  task automatic test_overflow();
    bit ok;
    logic [8:0] exp_pos, exp_neg;
`ifdef FIXP_ACC_SUM_SAT_EN
    exp_pos = 9'h0FF;
    exp_neg = 9'h100;
`else
    exp_pos = 9'h1FC;
    exp_neg = 9'h080;
`endif
    group_len = 4'd4;
    for (int i = 0; i < 4; i++) send(8'h7F, ok);
    data_in_tvalid = 1'b0;
    wait_sum(ok);
    total++; if (!ok || sum_out_tdata !== exp_pos) begin bad++; $display("FAIL ovf_pos_sum got=%h want=%h", sum_out_tdata, exp_pos); end
    total++; if (sum_ovf !== 1'b1) begin bad++; $display("FAIL ovf_pos_flag got=%b want=1", sum_ovf); end
    $display("overflow+: sum=%h ovf=%b", sum_out_tdata, sum_ovf);
    accept_sum();
    group_len = 4'd3;
    for (int i = 0; i < 3; i++) send(8'h80, ok);
    data_in_tvalid = 1'b0;
    wait_sum(ok);
    total++; if (!ok || sum_out_tdata !== exp_neg) begin bad++; $display("FAIL ovf_neg_sum got=%h want=%h", sum_out_tdata, exp_neg); end
    total++; if (sum_ovf !== 1'b1) begin bad++; $display("FAIL ovf_neg_flag got=%b want=1", sum_ovf); end
    $display("overflow-: sum=%h ovf=%b", sum_out_tdata, sum_ovf);
    accept_sum();
  endtask

  task automatic test_gaps();
    bit ok;
    logic [7:0] terms [3];
    terms[0] = 8'd10;
    terms[1] = 8'hFD;
    terms[2] = 8'd20;
    group_len = 4'd3;
    for (int i = 0; i < 3; i++) begin
      send(terms[i], ok);
      if (i == 0) group_len = 4'd5;
      data_in_tvalid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_sum(ok);
    total++; if (!ok) begin bad++; $display("FAIL gaps_close got=none want=sum after 3 terms"); end
    total++; if (sum_out_tdata !== 9'h01B) begin bad++; $display("FAIL gaps_sum got=%h want=01b", sum_out_tdata); end
    total++; if (sum_ovf !== 1'b0) begin bad++; $display("FAIL gaps_ovf got=%b want=0", sum_ovf); end
    $display("gaps: sum=%h ovf=%b", sum_out_tdata, sum_ovf);
    accept_sum();
  endtask

  task automatic test_reset_mid();
    bit ok;
    group_len = 4'd4;
    send(8'd10, ok);
    send(8'd20, ok);
    data_in_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    repeat (5) @(negedge clk);
    total++; if (sum_out_tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_tvalid got=%b want=0", sum_out_tvalid); end
    group_len = 4'd2;
    send(8'd3, ok);
    send(8'd3, ok);
    data_in_tvalid = 1'b0;
    wait_sum(ok);
    total++; if (!ok || sum_out_tdata !== 9'd6) begin bad++; $display("FAIL rstmid_sum got=%h want=006", sum_out_tdata); end
    $display("reset-mid: sum=%h", sum_out_tdata);
    accept_sum();
  endtask

  initial begin
    rst = 1'b1;
    group_len = '0;
    data_in_tdata = '0;
    data_in_tvalid = 1'b0;
    sum_out_tready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_len_zero_one();
    test_backpressure();
    test_overflow();
    test_gaps();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
